// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: S-box tables, FSM state type and beat-count helper.
// The inverse table is only compiled when AES_SBOX_INV_EN is defined.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } aes_state_e;

    function automatic int BEATS(input int lanes);
        return 16 / lanes;
    endfunction

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef AES_SBOX_INV_EN
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte S-box lookup with optional output register (SBOX_PIPE).
// Inverse lookup exists only when AES_SBOX_INV_EN is defined; otherwise i_dec is ignored.
module aes_sbox_byte
    import aes_pkg::*;
#(
    parameter int SBOX_PIPE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_dec,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_lut;

`ifdef AES_SBOX_INV_EN
    assign w_lut = i_dec ? SBOX_INV[i_byte] : SBOX_FWD[i_byte];
`else
    logic w_unused_dec;
    assign w_unused_dec = i_dec;
    assign w_lut        = SBOX_FWD[i_byte];
`endif

    generate
        if (SBOX_PIPE != 0) begin : g_pipe
            logic [7:0] r_byte;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_byte <= '0;
                end else begin
                    r_byte <= w_lut;
                end
            end

            assign o_byte = r_byte;
        end else begin : g_comb
            logic [1:0] w_unused_ctl;
            assign w_unused_ctl = {clk, rst};
            assign o_byte       = w_lut;
        end
    endgenerate

endmodule

// File: rtl/aes_subbytes_lanes.sv
// AES SubBytes engine: LANES bytes per beat, MSB group first, valid/ready on both sides.
// Decrypt support depends on AES_SBOX_INV_EN (see aes_sbox_byte).
module aes_subbytes_lanes
    import aes_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int SBOX_PIPE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         decrypt_i,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    localparam int NBEATS = aes_pkg::BEATS(LANES);
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int GW     = 8 * LANES;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    aes_state_e     r_state;
    logic [CW-1:0]  r_beat;
    logic [127:0]   r_data_in;
    logic           r_dec;
    logic [127:0]   r_data_out;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_last;
    logic [CW-1:0]  w_rd_grp;
    logic [CW-1:0]  w_wr_grp;
    logic           w_wr_en;
    logic [6:0]     w_rd_base;
    logic [6:0]     w_wr_base;
    logic [GW-1:0]  w_grp_in;
    logic [GW-1:0]  w_grp_out;

    assign w_in_ready = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready_i);
    assign w_accept   = in_valid_i & w_in_ready;
    assign w_last     = (r_beat == LAST_BEAT);

    // Beat k reads byte group NBEATS-1-k, so the most significant group goes first.
    assign w_rd_grp  = LAST_BEAT - r_beat;
    assign w_rd_base = 7'(int'(w_rd_grp) * GW);
    assign w_wr_base = 7'(int'(w_wr_grp) * GW);
    assign w_grp_in  = r_data_in[w_rd_base +: GW];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            aes_sbox_byte #(
                .SBOX_PIPE(SBOX_PIPE)
            ) u_sbox (
                .clk    (clk),
                .rst    (rst),
                .i_dec  (r_dec),
                .i_byte (w_grp_in[8*gi +: 8]),
                .o_byte (w_grp_out[8*gi +: 8])
            );
        end

        // With a registered lookup, the write position trails the read position by one cycle.
        if (SBOX_PIPE != 0) begin : g_wr_pipe
            logic          r_wr_en;
            logic [CW-1:0] r_wr_grp;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_en  <= 1'b0;
                    r_wr_grp <= '0;
                end else begin
                    r_wr_en  <= (r_state == ST_RUN);
                    r_wr_grp <= w_rd_grp;
                end
            end

            assign w_wr_en  = r_wr_en;
            assign w_wr_grp = r_wr_grp;
        end else begin : g_wr_comb
            assign w_wr_en  = (r_state == ST_RUN);
            assign w_wr_grp = w_rd_grp;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_data_in <= '0;
            r_dec     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data_in <= data_i;
                r_dec     <= decrypt_i;
                r_beat    <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_beat <= w_last ? '0 : r_beat + CW'(1);
                    if (w_last) begin
                        r_state <= (SBOX_PIPE != 0) ? ST_DRAIN : ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready_i) begin
                        r_state <= in_valid_i ? ST_RUN : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_wr_en) begin
            r_data_out[w_wr_base +: GW] <= w_grp_out;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = (r_state == ST_HOLD);
    assign busy_o      = (r_state != ST_IDLE);
    assign data_o      = r_data_out;

endmodule
